// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state type and sizing helpers for piso_serializer
package piso_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Number of bits per frame, including the appended parity bit when enabled.
   function automatic int frame_len(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel word load handshake for piso_serializer
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;

   modport master (
      output load_data,
      output load_valid,
      input  load_ready
   );

   modport slave (
      input  load_data,
      input  load_valid,
      output load_ready
   );
endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - loadable shift register; next_bit is the bit that becomes head after one shift
module piso_shift_reg #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             next_bit
);

   logic [WIDTH-1:0] sr;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr <= '0;
      end else if (load) begin
         sr <= din;
      end else if (shift) begin
         sr <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      end
   end

   assign next_bit = MSB_FIRST ? sr[WIDTH-2] : sr[1];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out stage with frame/busy flags
// Optional even-parity trailer bit: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer
   import piso_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   piso_serializer_if.slave   load,
   output logic               dout,
   output logic               dout_valid,
   output logic               frame_start,
   output logic               busy
);

   localparam int                CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(frame_len(WIDTH) - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             xfer;
   logic             first_bit;
   logic             next_bit;

   assign last      = (cnt == LAST_CNT);
   assign xfer      = load.load_valid && load.load_ready;
   assign first_bit = MSB_FIRST ? load.load_data[WIDTH-1] : load.load_data[0];

   assign load.load_ready = !rst && ((state == IDLE) || (state == SHIFT && last));

   piso_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (xfer),
      .shift    ((state == SHIFT) && !last && !xfer),
      .din      (load.load_data),
      .next_bit (next_bit)
   );

`ifdef PISO_SERIALIZER_PARITY_EN
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH - 1);
   logic parity_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (xfer) begin
         parity_q <= ^load.load_data;
      end
   end
`endif

   // dout is fed one bit ahead from the shift register so it stays a flop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         dout        <= 1'b0;
         dout_valid  <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (xfer) begin
            state       <= SHIFT;
            cnt         <= '0;
            dout        <= first_bit;
            dout_valid  <= 1'b1;
            busy        <= 1'b1;
            frame_start <= 1'b1;
         end else if (state == SHIFT && !last) begin
            cnt  <= cnt + 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
            dout <= (cnt == DATA_LAST) ? parity_q : next_bit;
`else
            dout <= next_bit;
`endif
         end else if (state == SHIFT) begin
            state      <= IDLE;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - randomized and directed bench for piso_serializer (MSB- and LSB-first instances)
module tb_piso_serializer;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   piso_serializer_if #(.WIDTH(W)) if_m ();
   piso_serializer_if #(.WIDTH(W)) if_l ();

   logic dout_m, dv_m, fs_m, busy_m;
   logic dout_l, dv_l, fs_l, busy_l;

   int checks   = 0;
   int failures = 0;

   bit qm[$];
   bit sm[$];
   bit ql[$];
   bit sl[$];
   bit last_xfer;

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk         (clk),
      .rst         (rst),
      .load        (if_m.slave),
      .dout        (dout_m),
      .dout_valid  (dv_m),
      .frame_start (fs_m),
      .busy        (busy_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk         (clk),
      .rst         (rst),
      .load        (if_l.slave),
      .dout        (dout_l),
      .dout_valid  (dv_l),
      .frame_start (fs_l),
      .busy        (busy_l)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs follow from the queue of bits still owed to the consumer.
   task automatic check_all(input bit exp_rdy);
      chk("ready_m", if_m.load_ready, exp_rdy);
      chk("ready_l", if_l.load_ready, exp_rdy);
      chk("valid_m", dv_m,   qm.size() > 0);
      chk("busy_m",  busy_m, qm.size() > 0);
      chk("dout_m",  dout_m, (qm.size() > 0) ? qm[0] : 1'b0);
      chk("start_m", fs_m,   (sm.size() > 0) ? sm[0] : 1'b0);
      chk("valid_l", dv_l,   ql.size() > 0);
      chk("busy_l",  busy_l, ql.size() > 0);
      chk("dout_l",  dout_l, (ql.size() > 0) ? ql[0] : 1'b0);
      chk("start_l", fs_l,   (sl.size() > 0) ? sl[0] : 1'b0);
   endtask

   task automatic push_frame(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         qm.push_back(d[W-1-i]);
         sm.push_back(i == 0);
         ql.push_back(d[i]);
         sl.push_back(i == 0);
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      qm.push_back(^d);
      sm.push_back(1'b0);
      ql.push_back(^d);
      sl.push_back(1'b0);
`endif
   endtask

   task automatic step(input logic r, input logic v, input logic [W-1:0] d);
      bit exp_rdy;
      @(negedge clk);
      rst             = r;
      if_m.load_valid = v;
      if_l.load_valid = v;
      if_m.load_data  = d;
      if_l.load_data  = d;
      #1;
      exp_rdy = !r && (qm.size() <= 1);
      check_all(exp_rdy);
      @(posedge clk);
      last_xfer = v && exp_rdy;
      if (qm.size() > 0) begin
         qm.delete(0);
         sm.delete(0);
         ql.delete(0);
         sl.delete(0);
      end
      if (r) begin
         qm.delete();
         sm.delete();
         ql.delete();
         sl.delete();
      end else if (last_xfer) begin
         push_frame(d);
      end
   endtask

   task automatic send(input logic [W-1:0] d);
      int n = 0;
      do begin
         step(1'b0, 1'b1, d);
         n++;
      end while (!last_xfer && n < 40);
      if (!last_xfer) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
   endtask

   initial begin
      if_m.load_valid = 1'b1;
      if_l.load_valid = 1'b1;
      if_m.load_data  = 8'hFF;
      if_l.load_data  = 8'hFF;
      @(posedge clk);

      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h5A);

      send(8'hA5);
      idle(W + 3);

      send(8'h3C);
      send(8'hC3);
      idle(2 * W + 3);

      send(8'h01);
      idle(W + 3);

      send(8'h96);
      idle(3);
      step(1'b1, 1'b0, '0);
      idle(2);
      send(8'hE1);
      idle(W + 3);

      send(8'h07);
      idle(W + 3);
      send(8'h03);
      idle(W + 3);

      for (int i = 0; i < 400; i++) begin
         step(($urandom % 45) == 0, ($urandom % 3) != 0, W'($urandom));
      end
      idle(2 * W + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
